// File: rtl/mux_n_reg_if.sv
// Bundles the channel-side and output-side signals of mux_n_reg.
// No logic; the DUT takes the slave modport and the driver takes the master.
// Channel i of in_data lives at bits [i*FIXED_POINT +: FIXED_POINT].
interface mux_n_reg_if #(
    parameter int FIXED_POINT = 16,
    parameter int NUM_IN      = 4
);
    localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*FIXED_POINT-1:0] in_data;
    logic [NUM_IN-1:0]             in_valid;
    logic [NUM_IN-1:0]             in_ready;
    logic [SEL_W-1:0]              selection;
    logic [FIXED_POINT-1:0]        out_data;
    logic [SEL_W-1:0]              out_channel;
    logic                          out_valid;
    logic                          out_ready;

    // Source side: feeds the channels and the select, consumes the output.
    modport master (
        output in_data, in_valid, selection, out_ready,
        input  in_ready, out_data, out_channel, out_valid
    );

    // The mux/register itself.
    modport slave (
        input  in_data, in_valid, selection, out_ready,
        output in_ready, out_data, out_channel, out_valid
    );
endinterface

// File: rtl/mux_n_reg.sv
// Purpose: select one of NUM_IN fixed-point channels (explicit select or round-robin) into a one-entry output register.
// Latency: one clock from input transfer to out_valid/out_data.
// Backpressure: while out_valid && !out_ready the word is held and every in_ready is low; drain+reload in one cycle gives full rate.
// Ports: clk, rst (sync, active-high); bus (slave modport): in_data/in_valid/in_ready per channel,
//        selection (MODE 0 only), out_data/out_channel/out_valid/out_ready.
module mux_n_reg #(
    parameter int FIXED_POINT = 16,
    parameter int NUM_IN      = 4,
    parameter int MODE        = 0
) (
    input logic         clk,
    input logic         rst,
    mux_n_reg_if.slave  bus
);
    localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;
    localparam int CW    = SEL_W + 1;

    logic [FIXED_POINT-1:0] data_q;
    logic [SEL_W-1:0]       chan_q;
    logic                   valid_q;
    logic [SEL_W-1:0]       ptr_q;

    logic                   load_en;
    logic                   gnt_vld;
    logic [SEL_W-1:0]       gnt_idx;
    logic [CW-1:0]          cand;
    logic [NUM_IN-1:0]      rdy;
    logic [FIXED_POINT-1:0] gnt_data;
    logic                   xfer;
    logic [SEL_W-1:0]       ptr_nxt;

    // Register may accept a word when empty or being drained this same cycle.
    assign load_en = !valid_q || bus.out_ready;

    // Grant selection. The extra bit on cand lets ptr+k be wrapped without overflow.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (MODE == 0) begin
            if ({1'b0, bus.selection} < CW'(NUM_IN)) begin
                gnt_vld = 1'b1;
                gnt_idx = bus.selection;
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                cand = {1'b0, ptr_q} + CW'(k);
                if (cand >= CW'(NUM_IN)) begin
                    cand = cand - CW'(NUM_IN);
                end
                if (!gnt_vld && bus.in_valid[cand[SEL_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand[SEL_W-1:0];
                end
            end
        end
    end

    // One-hot ready and the granted channel's word; reset forces ready low.
    always_comb begin
        rdy      = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                rdy[i]   = gnt_vld && load_en && !rst;
                gnt_data = bus.in_data[i*FIXED_POINT +: FIXED_POINT];
            end
        end
    end

    assign xfer    = |(rdy & bus.in_valid);
    assign ptr_nxt = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            if (xfer) begin
                data_q  <= gnt_data;
                chan_q  <= gnt_idx;
                valid_q <= 1'b1;
                if (MODE == 1) begin
                    ptr_q <= ptr_nxt;
                end
            end else if (bus.out_ready) begin
                // Drained (or already empty) with nothing new arriving.
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = rdy;
    assign bus.out_data    = data_q;
    assign bus.out_channel = chan_q;
    assign bus.out_valid   = valid_q;
endmodule

// File: tb/tb_mux_n_reg.sv
module tb_mux_n_reg;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    // b0: explicit select, 4 channels; b1: explicit select, 3 channels; b2: round-robin, 4 channels.
    mux_n_reg_if #(.FIXED_POINT(16), .NUM_IN(4)) b0 ();
    mux_n_reg_if #(.FIXED_POINT(16), .NUM_IN(3)) b1 ();
    mux_n_reg_if #(.FIXED_POINT(16), .NUM_IN(4)) b2 ();

    mux_n_reg #(.FIXED_POINT(16), .NUM_IN(4), .MODE(0)) d0 (.clk(clk), .rst(rst), .bus(b0.slave));
    mux_n_reg #(.FIXED_POINT(16), .NUM_IN(3), .MODE(0)) d1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mux_n_reg #(.FIXED_POINT(16), .NUM_IN(4), .MODE(1)) d2 (.clk(clk), .rst(rst), .bus(b2.slave));

    task automatic test_reset();
        rst          = 1'b1;
        b0.in_data   = '0;
        b0.in_data[2*16 +: 16] = 16'h5555;
        b0.in_valid  = 4'b1111;
        b0.selection = 2'd2;
        b0.out_ready = 1'b1;
        b1.in_data   = '0;
        b1.in_valid  = 3'b000;
        b1.selection = 2'd0;
        b1.out_ready = 1'b1;
        b2.in_data   = '0;
        b2.in_valid  = 4'b1111;
        b2.selection = 2'd0;
        b2.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (b0.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", b0.out_valid);
            else passed++;
            total++;
            if (b0.out_data !== 16'h0000) $display("FAIL reset_out_data: got %h want 0000", b0.out_data);
            else passed++;
            total++;
            if (b0.in_ready !== 4'b0000) $display("FAIL reset_in_ready_b0: got %b want 0000", b0.in_ready);
            else passed++;
            total++;
            if (b2.in_ready !== 4'b0000) $display("FAIL reset_in_ready_b2: got %b want 0000", b2.in_ready);
            else passed++;
        end
        b2.in_valid = 4'b0000;
        rst = 1'b0;
        #1;
        total++;
        if (b0.in_ready !== 4'b0100) $display("FAIL post_reset_in_ready: got %b want 0100", b0.in_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (b0.out_valid !== 1'b1 || b0.out_data !== 16'h5555 || b0.out_channel !== 2'd2)
            $display("FAIL post_reset_load: got v=%b d=%h ch=%0d want v=1 d=5555 ch=2",
                     b0.out_valid, b0.out_data, b0.out_channel);
        else passed++;
    endtask

    task automatic test_stream();
        logic [15:0] want;
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) begin
                want = 16'h1234 + 16'(i - 1);
                total++;
                if (b0.out_valid !== 1'b1 || b0.out_data !== want || b0.out_channel !== 2'd2)
                    $display("FAIL stream_out[%0d]: got v=%b d=%h ch=%0d want v=1 d=%h ch=2",
                             i - 1, b0.out_valid, b0.out_data, b0.out_channel, want);
                else passed++;
            end
            if (i < 6) begin
                b0.in_data[2*16 +: 16] = 16'h1234 + 16'(i);
                b0.in_valid  = 4'b1111;
                b0.selection = 2'd2;
                b0.out_ready = 1'b1;
                #1;
                total++;
                if (b0.in_ready !== 4'b0100) $display("FAIL stream_in_ready[%0d]: got %b want 0100", i, b0.in_ready);
                else passed++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        b0.in_data[2*16 +: 16] = 16'h00AA;
        b0.selection = 2'd2;
        b0.out_ready = 1'b1;
        @(negedge clk);
        b0.out_ready = 1'b0;
        b0.in_data[2*16 +: 16] = 16'h00BB;
        b0.in_data[1*16 +: 16] = 16'h0011;
        b0.selection = 2'd1;
        #1;
        total++;
        if (b0.out_data !== 16'h00AA) $display("FAIL bp_load: got %h want 00AA", b0.out_data);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (b0.out_valid !== 1'b1 || b0.out_data !== 16'h00AA || b0.out_channel !== 2'd2)
                $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d want v=1 d=00AA ch=2",
                         c, b0.out_valid, b0.out_data, b0.out_channel);
            else passed++;
            total++;
            if (b0.in_ready !== 4'b0000) $display("FAIL bp_in_ready[%0d]: got %b want 0000", c, b0.in_ready);
            else passed++;
        end
        b0.out_ready = 1'b1;
        #1;
        total++;
        if (b0.in_ready !== 4'b0010) $display("FAIL bp_release_ready: got %b want 0010", b0.in_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (b0.out_valid !== 1'b1 || b0.out_data !== 16'h0011 || b0.out_channel !== 2'd1)
            $display("FAIL bp_next_word: got v=%b d=%h ch=%0d want v=1 d=0011 ch=1",
                     b0.out_valid, b0.out_data, b0.out_channel);
        else passed++;
        b0.in_valid = 4'b0000;
    endtask

    task automatic test_invalid_select();
        b1.in_data   = '0;
        b1.in_data[0 +: 16] = 16'h0777;
        b1.in_valid  = 3'b111;
        b1.selection = 2'd0;
        b1.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (b1.out_valid !== 1'b1 || b1.out_data !== 16'h0777)
            $display("FAIL badsel_preload: got v=%b d=%h want v=1 d=0777", b1.out_valid, b1.out_data);
        else passed++;
        b1.selection = 2'd3;
        #1;
        total++;
        if (b1.in_ready !== 3'b000) $display("FAIL badsel_in_ready: got %b want 000", b1.in_ready);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (b1.out_valid !== 1'b0) $display("FAIL badsel_drain[%0d]: got %b want 0", c, b1.out_valid);
            else passed++;
            total++;
            if (b1.in_ready !== 3'b000) $display("FAIL badsel_ready[%0d]: got %b want 000", c, b1.in_ready);
            else passed++;
        end
        b1.in_valid = 3'b000;
    endtask

    task automatic test_round_robin();
        int exp_ch [6] = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < 4; k++) b2.in_data[k*16 +: 16] = 16'h0A00 + 16'(k);
        b2.in_valid  = 4'b1111;
        b2.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (b2.in_ready !== (4'b0001 << exp_ch[i]))
                $display("FAIL rr_in_ready[%0d]: got %b want ch %0d", i, b2.in_ready, exp_ch[i]);
            else passed++;
            @(negedge clk);
            total++;
            if (b2.out_valid !== 1'b1 || b2.out_channel !== 2'(exp_ch[i]) || b2.out_data !== 16'h0A00 + 16'(exp_ch[i]))
                $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, b2.out_valid,
                         b2.out_channel, b2.out_data, exp_ch[i], 16'h0A00 + 16'(exp_ch[i]));
            else passed++;
        end
        b2.in_valid = 4'b0000;
    endtask

    task automatic test_rr_skip_reset();
        int exp_ch [5] = '{1, 3, 1, 3, 1};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b2.in_valid  = 4'b1010;
        b2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (b2.out_valid !== 1'b1 || b2.out_channel !== 2'(exp_ch[i]))
                $display("FAIL rr_skip[%0d]: got v=%b ch=%0d want v=1 ch=%0d",
                         i, b2.out_valid, b2.out_channel, exp_ch[i]);
            else passed++;
        end
        // Pointer now sits at 2 with a word held; reset while stalled.
        b2.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (b2.in_ready !== 4'b0000) $display("FAIL midrst_in_ready: got %b want 0000", b2.in_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (b2.out_valid !== 1'b0 || b2.out_data !== 16'h0000 || b2.out_channel !== 2'd0)
            $display("FAIL midrst_out: got v=%b d=%h ch=%0d want v=0 d=0000 ch=0",
                     b2.out_valid, b2.out_data, b2.out_channel);
        else passed++;
        rst = 1'b0;
        b2.out_ready = 1'b1;
        b2.in_valid  = 4'b1111;
        #1;
        total++;
        if (b2.in_ready !== 4'b0001) $display("FAIL midrst_ptr: got %b want 0001", b2.in_ready);
        else passed++;
        @(negedge clk);
        total++;
        if (b2.out_valid !== 1'b1 || b2.out_channel !== 2'd0)
            $display("FAIL midrst_first_grant: got v=%b ch=%0d want v=1 ch=0", b2.out_valid, b2.out_channel);
        else passed++;
        b2.in_valid = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_invalid_select();
        test_round_robin();
        test_rr_skip_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised successor to the 2:1 combinational operand mux used in the CORDIC datapath.
- Selects one of NUM_IN fixed-point channels and registers it into a single-entry output stage with a valid/ready handshake.
- MODE chooses the selection policy: explicit selection input, or round-robin arbitration among valid inputs.
- Sits between CORDIC operand sources (angle/x/y feeders, iteration feedback) and the iteration stage, so the stage can apply backpressure.

Parameters:
- FIXED_POINT, 16, data width of each channel in bits.
- NUM_IN, 4, number of input channels (>= 2).
- MODE, 0, 0 = explicit select via `selection`; 1 = round-robin arbitration (`selection` ignored).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  NUM_IN*FIXED_POINT  packed channels; channel i at bits [i*FIXED_POINT +: FIXED_POINT].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; combinational, at most one bit high.
- selection  input  SEL_W  channel index for MODE 0. SEL_W = ceil(log2(NUM_IN)), minimum 1.
- out_data  output  FIXED_POINT  registered selected word.
- out_channel  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (rst high at a clock edge):
  - out_valid=0, out_data=0, out_channel=0, round-robin pointer ptr=0.
  - in_ready is forced to all 0 while rst is high.
  - Reset mid-transfer discards the held word; no handshake completes in that cycle.
- load_en = !out_valid || out_ready. The output register can take a new word when it is empty or being drained in the same cycle.
- Grant, MODE 0:
  - g = selection.
  - If selection >= NUM_IN: no grant, in_ready all 0, register not loaded.
- Grant, MODE 1:
  - g = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1.
  - No valid input means no grant.
- in_ready[g] = load_en && grant exists; all other in_ready bits are 0. in_ready does not depend on in_valid[g] in MODE 0, but does in MODE 1 through grant existence.
- Input transfer when in_valid[g] && in_ready[g]. At the next edge: out_data <= channel g, out_channel <= g, out_valid <= 1.
- MODE 1 only: on a transfer, ptr <= (g+1) mod NUM_IN. ptr is unchanged otherwise.
- Output transfer when out_valid && out_ready. If no input transfer happens in the same cycle, out_valid <= 0 at the next edge.
- Simultaneous output drain and input transfer: the register is reloaded and out_valid stays 1. This gives full throughput of one word per cycle with out_ready held high.
- Latency: exactly 1 clock from input transfer to out_valid/out_data.
- Stall (out_valid && !out_ready):
  - out_data and out_channel are held stable, all in_ready are 0.
  - Changes to selection or in_valid have no effect on the held word.
- Data passes bit-exact; no sign extension or rounding. Channels are FIXED_POINT wide, the same as the codebase fixed-point format.
- Pointer wrap: ptr = NUM_IN-1 followed by a transfer from channel NUM_IN-1 sets ptr to 0.
- No combinational path from in_data to out_data. The in_ready path depends on out_valid, out_ready, selection (MODE 0), in_valid (MODE 1) and ptr.

Test Plan:
1. Reset: hold rst 2 cycles with all in_valid=1 and out_ready=1 -> out_valid=0, out_data=0, in_ready=0000 throughout; first post-reset edge loads a word.
2. MODE 0 stream: NUM_IN=4, selection=2, in_data ch2 = 0x1234, 0x1235, ... valid every cycle, out_ready=1 -> in_ready=0100; out_data follows 1 cycle later each cycle, out_channel=2; no bubbles.
3. Backpressure: MODE 0, load 0x00AA, then out_ready=0 for 3 cycles while ch2 changes to 0x00BB and selection changes to 1 -> out_data stays 0x00AA, in_ready=0000; after out_ready=1, the next word comes from channel 1.
4. Invalid select: NUM_IN=3, selection=3, all in_valid=1 -> in_ready=000; out_valid drains to 0 and stays 0.
5. Round-robin fairness: MODE 1, NUM_IN=4, all in_valid=1, out_ready=1 -> out_channel sequence 0,1,2,3,0,1 (ptr wrap from 3 to 0 checked).
6. Round-robin skip and mid-reset: MODE 1, in_valid=1010, ptr=0 -> grants 1,3,1,3. Asserting rst while out_valid=1 and out_ready=0 -> out_valid=0 and ptr=0 next cycle; the held word is never transferred.
